// File: rtl/linear_interpolator_pkg.sv
// Shared definitions for the linear interpolator: FSM state encoding and the
// default memory map / fixed-point format used by the Euler solver system.
package interp_pkg;

    localparam int DEF_DATA_WIDTH    = 64;
    localparam int DEF_ADDRESS_WIDTH = 13;
    localparam int DEF_FRAC_BITS     = 32;

    localparam int DEF_N_ADDR     = 0;
    localparam int DEF_ALPHA_ADDR = 1;
    localparam int DEF_U0_BASE    = 16;
    localparam int DEF_U1_BASE    = 1024;
    localparam int DEF_OUT_BASE   = 2048;
    localparam int DEF_MAX_N      = 1008;

    typedef enum logic [2:0] {
        IDLE,
        RD_HDR,
        LATCH_HDR,
        RD_EL,
        CALC,
        WR,
        FIN,
        WAIT_LOW
    } state_t;

endpackage

// File: rtl/linear_interpolator_fx_mul.sv
// Signed fixed-point multiply: full-width product, then the word-sized slice
// starting at FRAC_BITS (floor truncation, no saturation). Registered, latency 1.
module fx_mul
    import interp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] p
);

    logic signed [2*DATA_WIDTH-1:0] a_ext;
    logic signed [2*DATA_WIDTH-1:0] b_ext;
    logic signed [2*DATA_WIDTH-1:0] prod;

    // Sign-extend to the product width so the low 2W bits are the exact product.
    assign a_ext = $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a});
    assign b_ext = $signed({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});
    assign prod  = a_ext * b_ext;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p <= '0;
        end else if (en) begin
            p <= DATA_WIDTH'(prod >>> FRAC_BITS);
        end
    end

endmodule

// File: rtl/linear_interpolator.sv
// Interpolation responder for the Euler solver: OUT[i] = U0[i] + alpha*(U1[i]-U0[i])
// over the shared RAM, three cycles per element, one-cycle DONE pulse at the end.
module linear_interpolator
    import interp_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int FRAC_BITS     = DEF_FRAC_BITS,
    parameter int N_ADDR        = DEF_N_ADDR,
    parameter int ALPHA_ADDR    = DEF_ALPHA_ADDR,
    parameter int U0_BASE       = DEF_U0_BASE,
    parameter int U1_BASE       = DEF_U1_BASE,
    parameter int OUT_BASE      = DEF_OUT_BASE,
    parameter int MAX_N         = DEF_MAX_N
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Interpolate_Enable,
    output logic                     Interpolate_DONE,
    output logic                     BUSY,
    output logic                     ERROR,
    output logic [ADDRESS_WIDTH-1:0] RAM_ADD_RD1,
    output logic [ADDRESS_WIDTH-1:0] RAM_ADD_RD2,
    input  logic [DATA_WIDTH-1:0]    RAM_DATA_RD1,
    input  logic [DATA_WIDTH-1:0]    RAM_DATA_RD2,
    output logic [ADDRESS_WIDTH-1:0] RAM_ADD_WR,
    output logic [DATA_WIDTH-1:0]    RAM_DATA_WR,
    output logic                     RAM_ENABLE_WR
);

    state_t                   state;
    state_t                   state_next;
    logic [DATA_WIDTH-1:0]    n_reg;
    logic [DATA_WIDTH-1:0]    alpha_reg;
    logic [DATA_WIDTH-1:0]    u0_reg;
    logic                     err_reg;
    logic [ADDRESS_WIDTH-1:0] idx;
    logic [ADDRESS_WIDTH-1:0] idx_next;
    logic [DATA_WIDTH-1:0]    diff;
    logic [DATA_WIDTH-1:0]    mul_p;
    logic                     hdr_too_big;
    logic                     hdr_empty;
    logic                     last_el;

    // N is an unsigned full word; anything above MAX_N is rejected unseen.
    assign hdr_too_big = RAM_DATA_RD1 > DATA_WIDTH'(MAX_N);
    assign hdr_empty   = RAM_DATA_RD1 == '0;
    assign idx_next    = idx + ADDRESS_WIDTH'(1);
    assign last_el     = DATA_WIDTH'(idx_next) == n_reg;
    assign diff        = RAM_DATA_RD2 - RAM_DATA_RD1;

    fx_mul #(
        .DATA_WIDTH(DATA_WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_fx_mul (
        .clk  (CLK),
        .rst_n(RST),
        .en   (state == CALC),
        .a    (diff),
        .b    (alpha_reg),
        .p    (mul_p)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            n_reg     <= '0;
            alpha_reg <= '0;
            u0_reg    <= '0;
            err_reg   <= 1'b0;
            idx       <= '0;
        end else begin
            state <= state_next;
            case (state)
                LATCH_HDR: begin
                    n_reg     <= RAM_DATA_RD1;
                    alpha_reg <= RAM_DATA_RD2;
                    err_reg   <= hdr_too_big;
                    idx       <= '0;
                end
                CALC:    u0_reg <= RAM_DATA_RD1;
                WR:      idx    <= idx_next;
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path through it leaves a signal unassigned (which would infer a latch).
    always_comb begin
        state_next       = state;
        Interpolate_DONE = 1'b0;
        BUSY             = 1'b0;
        ERROR            = 1'b0;
        RAM_ADD_RD1      = '0;
        RAM_ADD_RD2      = '0;
        RAM_ADD_WR       = '0;
        RAM_DATA_WR      = '0;
        RAM_ENABLE_WR    = 1'b0;

        case (state)
            IDLE: begin
                if (Interpolate_Enable) state_next = RD_HDR;
            end
            RD_HDR: begin
                BUSY        = 1'b1;
                RAM_ADD_RD1 = ADDRESS_WIDTH'(N_ADDR);
                RAM_ADD_RD2 = ADDRESS_WIDTH'(ALPHA_ADDR);
                state_next  = LATCH_HDR;
            end
            LATCH_HDR: begin
                BUSY = 1'b1;
                if (hdr_empty || hdr_too_big) state_next = FIN;
                else                          state_next = RD_EL;
            end
            RD_EL: begin
                BUSY        = 1'b1;
                RAM_ADD_RD1 = ADDRESS_WIDTH'(U0_BASE) + idx;
                RAM_ADD_RD2 = ADDRESS_WIDTH'(U1_BASE) + idx;
                state_next  = CALC;
            end
            CALC: begin
                BUSY       = 1'b1;
                state_next = WR;
            end
            WR: begin
                BUSY          = 1'b1;
                RAM_ADD_WR    = ADDRESS_WIDTH'(OUT_BASE) + idx;
                RAM_DATA_WR   = u0_reg + mul_p;
                RAM_ENABLE_WR = 1'b1;
                state_next    = last_el ? FIN : RD_EL;
            end
            FIN: begin
                BUSY             = 1'b1;
                Interpolate_DONE = 1'b1;
                ERROR            = err_reg;
                state_next       = WAIT_LOW;
            end
            WAIT_LOW: begin
                // A held request must drop before another job may start.
                if (!Interpolate_Enable) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
